// File: rtl/vend_pkg.sv
// Shared types and defaults for the vending dispense arbiter and its lane picker.
package vend_pkg;

   localparam int DEF_TIMEOUT_CYCLES  = 200;
   localparam int DEF_COOLDOWN_CYCLES = 8;

   typedef logic [1:0] vend_state_t;

   localparam vend_state_t ST_IDLE     = 2'd0;
   localparam vend_state_t ST_DISPENSE = 2'd1;
   localparam vend_state_t ST_COOLDOWN = 2'd2;

   // Lane index width; a single-lane build still needs one bit to carry an index.
   function automatic int lane_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vend_rr_picker.sv
// Rotate-priority request picker: first set request at or above i_rr_ptr, wrapping at N_LANES-1.
module vend_rr_picker
   import vend_pkg::*;
#(
   parameter  int N_LANES = 4,
   localparam int LW      = lane_w(N_LANES)
) (
   input  logic [N_LANES-1:0] i_req,
   input  logic [LW-1:0]      i_rr_ptr,
   output logic               o_valid,
   output logic [LW-1:0]      o_lane
);

   logic [LW-1:0] w_idx;

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      o_valid = 1'b0;
      o_lane  = '0;
      w_idx   = '0;
      // Walk offsets from farthest to nearest so the nearest set request is the last one written.
      for (int i = N_LANES - 1; i >= 0; i--) begin
         w_idx = LW'((int'(i_rr_ptr) + i) % N_LANES);
         if (i_req[w_idx]) begin
            o_valid = 1'b1;
            o_lane  = w_idx;
         end
      end
   end

endmodule

// File: rtl/vend_dispense_arbiter.sv
// Round-robin owner of the shared dispense motor: grants a lane, times the motor against the drop
// sensor, reports done/fault to that lane, then lets the mechanism settle before the next grant.
module vend_dispense_arbiter
   import vend_pkg::*;
#(
   parameter  int N_LANES         = 4,
   parameter  int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
   parameter  int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
   localparam int LW              = lane_w(N_LANES),
   localparam int TW              = $clog2(TIMEOUT_CYCLES + 1),
   localparam int CW              = $clog2(COOLDOWN_CYCLES + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_LANES-1:0] vend_req,
   input  logic               product_dropped,
   output logic               motor_on,
   output logic [LW-1:0]      motor_sel,
   output logic [N_LANES-1:0] vend_done,
   output logic [N_LANES-1:0] vend_fault,
   output logic               busy
);

   vend_state_t        r_state;
   logic [LW-1:0]      r_rr_ptr;
   logic [TW-1:0]      r_timer;
   logic [CW-1:0]      r_cool;
   logic               r_motor_on;
   logic [LW-1:0]      r_motor_sel;
   logic [N_LANES-1:0] r_done;
   logic [N_LANES-1:0] r_fault;

   logic               w_pick_valid;
   logic [LW-1:0]      w_pick_lane;
   logic [LW-1:0]      w_next_ptr;
   logic [N_LANES-1:0] w_lane_onehot;

   vend_rr_picker #(
      .N_LANES (N_LANES)
   ) u_picker (
      .i_req    (vend_req),
      .i_rr_ptr (r_rr_ptr),
      .o_valid  (w_pick_valid),
      .o_lane   (w_pick_lane)
   );

   // Explicit wrap so non-power-of-two lane counts return to lane 0 after N_LANES-1.
   assign w_next_ptr    = (r_motor_sel == LW'(N_LANES - 1)) ? '0 : r_motor_sel + 1'b1;
   assign w_lane_onehot = {{(N_LANES - 1){1'b0}}, 1'b1} << r_motor_sel;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_rr_ptr    <= '0;
         r_timer     <= '0;
         r_cool      <= '0;
         r_motor_on  <= 1'b0;
         r_motor_sel <= '0;
         r_done      <= '0;
         r_fault     <= '0;
      end else begin
         r_done  <= '0;
         r_fault <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_pick_valid) begin
                  r_state     <= ST_DISPENSE;
                  r_motor_on  <= 1'b1;
                  r_motor_sel <= w_pick_lane;
                  r_timer     <= TW'(1);
               end
            end
            ST_DISPENSE: begin
               // A drop on the timeout edge still counts as success.
               if (product_dropped || (r_timer == TW'(TIMEOUT_CYCLES))) begin
                  if (product_dropped) begin
                     r_done <= w_lane_onehot;
                  end else begin
                     r_fault <= w_lane_onehot;
                  end
                  r_state    <= ST_COOLDOWN;
                  r_motor_on <= 1'b0;
                  r_timer    <= '0;
                  r_cool     <= CW'(1);
                  r_rr_ptr   <= w_next_ptr;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            ST_COOLDOWN: begin
               if (r_cool == CW'(COOLDOWN_CYCLES)) begin
                  r_state <= ST_IDLE;
                  r_cool  <= '0;
               end else begin
                  r_cool <= r_cool + 1'b1;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_motor_on <= 1'b0;
            end
         endcase
      end
   end

   assign motor_on   = r_motor_on;
   assign motor_sel  = r_motor_sel;
   assign vend_done  = r_done;
   assign vend_fault = r_fault;
   assign busy       = (r_state != ST_IDLE);

endmodule

// File: doc/vend_dispense_arbiter.md
Name: vend_dispense_arbiter

Overview:
Shares one physical dispense motor between N_LANES vending-machine controllers. Each lane raises a vend request once its coin/selection sequence completes. The arbiter grants lanes round-robin, drives and times the motor, and watches the drop sensor. It reports success or fault back to the granted lane. It sits between the per-lane vending_machine_controller instances and the motor driver.

Parameters:
N_LANES, 4, number of requesting vending lanes (2..8)
TIMEOUT_CYCLES, 200, maximum motor-on cycles waiting for product_dropped before fault
COOLDOWN_CYCLES, 8, motor-off settle cycles after each dispense before the next grant

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
vend_req  input  N_LANES  per-lane level request; held high until that lane's done/fault
product_dropped  input  1  drop sensor, synchronous to clk, high when product has fallen
motor_on  output  1  motor enable
motor_sel  output  $clog2(N_LANES)  lane whose chute the motor drives; valid while motor_on
vend_done  output  N_LANES  one-cycle pulse on the granted lane's bit: dispense succeeded
vend_fault  output  N_LANES  one-cycle pulse on the granted lane's bit: timeout, no drop
busy  output  1  high whenever state is not IDLE

Behaviour:
- One clock (clk). Synchronous active-high reset (reset).
- Reset (incl. mid-dispense): state=IDLE; rr_ptr=0; timer=0; motor_on=0; motor_sel=0; vend_done=0; vend_fault=0; busy=0. All take effect at the reset edge.
- States: IDLE, DISPENSE, COOLDOWN.
- IDLE: at edge k, if vend_req!=0, select the first set bit searching from rr_ptr upward with wrap.
  - After edge k: state=DISPENSE, motor_on=1, motor_sel=lane, timer=1, busy=1.
  - Grant latency is 1 cycle.
- DISPENSE:
  - Each edge with product_dropped=1: vend_done[lane]=1 for 1 cycle, motor_on=0, go to COOLDOWN.
  - Else if timer==TIMEOUT_CYCLES: vend_fault[lane]=1 for 1 cycle, motor_on=0, go to COOLDOWN.
  - Else timer++.
  - Drop and timeout on the same edge: done wins, no fault.
- Motor-on duration is 1..TIMEOUT_CYCLES cycles inclusive.
- COOLDOWN:
  - motor_on=0; motor_sel holds the last lane.
  - Lasts exactly COOLDOWN_CYCLES cycles, then goes to IDLE.
  - On COOLDOWN entry, rr_ptr=(lane+1) mod N_LANES.
  - COOLDOWN_CYCLES=0 is illegal; minimum is 1.
- Minimum request-to-request spacing for back-to-back grants: dispense + COOLDOWN_CYCLES + 1 IDLE cycle.
- Request deasserted during DISPENSE: no abort; the dispense completes and done/fault still pulse.
- product_dropped in IDLE or COOLDOWN is ignored.
- Granted lane's req still high when IDLE is re-entered: treated as a new request, subject to round-robin. The lane must drop req on seeing done/fault.
- Requests from other lanes during DISPENSE/COOLDOWN wait; no starvation. Any pending lane is granted within N_LANES-1 other grants.
- vend_done and vend_fault are never both high. At most one bit of either is high in a cycle.
- Timer width: $clog2(TIMEOUT_CYCLES+1). Lane index width: $clog2(N_LANES). rr_ptr wraps modulo N_LANES; non-power-of-2 N_LANES must wrap at N_LANES-1 to 0.

Decomposition:
- Package vend_pkg:
  - state enum (IDLE, DISPENSE, COOLDOWN)
  - default TIMEOUT_CYCLES / COOLDOWN_CYCLES constants
  - lane-index width function
- Sub-module vend_rr_picker: combinational rotate-priority select of vend_req from rr_ptr. Outputs valid and lane index. Reused by later coin-validator sharing.

Test Plan:
- Reset, vend_req=4'b0010, product_dropped high 5 cycles after grant -> motor_on high 1 cycle after req with motor_sel=1, motor_on falls the edge drop is sampled, vend_done=4'b0010 for 1 cycle, busy low after 8 COOLDOWN cycles.
- vend_req=4'b0001, never drop -> motor_on high exactly 200 cycles, vend_fault=4'b0001 pulse, vend_done stays 0.
- vend_req=4'b1111 held, drop 3 cycles after each grant -> grant order lanes 0,1,2,3,0; each gap is COOLDOWN_CYCLES+1 motor-off cycles.
- Drop asserted on the same edge timer reaches 200 -> vend_done pulses, vend_fault=0.
- Assert reset at cycle 50 of a dispense -> motor_on=0 and busy=0 next cycle, no done/fault pulse, next grant goes to lane 0.
- product_dropped pulsed in IDLE and in COOLDOWN with vend_req=0 -> no outputs change, state unchanged.
